obi_mgr: RTL and testbench

- OBI manager (initiator). It converts a simple command stream (address, write data, we, be) into OBI A-channel requests and returns R-channel responses as a one-cycle response strobe.
- It is the counterpart of the team's OBI subordinate peripherals and is used to drive them from test sequencers and from the SPI control path.
- Responses are in order. Up to MAX_OUTSTANDING granted transactions may await rvalid at once.

---
 rtl/obi_mgr.sv | 189 ++++++++++++++++++
 tb/tb_obi_mgr.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/obi_mgr.sv
// ============================================================================
// obi_mgr : OBI manager turning a command stream into in-order OBI transactions.
// Optional watchdog: define OBI_MGR_TIMEOUT_EN.      Revision: 1.0
// ============================================================================
`default_nettype none

module obi_mgr #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2,
  parameter int TIMEOUT_CYCLES  = 256
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
  input  logic                    cmd_we_i,
  input  logic [DATA_WIDTH/8-1:0] cmd_be_i,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,
  output logic                    obi_req_o,
  input  logic                    obi_gnt_i,
  output logic [ADDR_WIDTH-1:0]   obi_addr_o,
  output logic                    obi_we_o,
  output logic [DATA_WIDTH/8-1:0] obi_be_o,
  output logic [DATA_WIDTH-1:0]   obi_wdata_o,
  input  logic                    obi_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   obi_rdata_i,
  output logic                    rsp_valid_o,
  output logic                    rsp_we_o,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    busy_o,
  output logic                    proto_err_o,
  output logic                    timeout_o
);

  localparam int BE_W = DATA_WIDTH / 8;
  localparam int CW   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW:0] MAX_C = (CW+1)'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  logic                       req_q,   req_d;
  logic [ADDR_WIDTH-1:0]      addr_q,  addr_d;
  logic                       we_q,    we_d;
  logic [BE_W-1:0]            be_q,    be_d;
  logic [DATA_WIDTH-1:0]      wdata_q, wdata_d;
  logic [CW-1:0]              cnt_q,   cnt_d;
  logic [MAX_OUTSTANDING-1:0] fifo_q,  fifo_d;
  logic                       rsp_valid_q, rsp_valid_d;
  logic                       rsp_we_q,    rsp_we_d;
  logic [DATA_WIDTH-1:0]      rsp_rdata_q, rsp_rdata_d;
  logic                       perr_q,      perr_d;

  logic          w_hs, w_acc, w_rv_ok, w_stray, w_busy;
  logic [CW-1:0] w_push_idx;
  state_t        w_state;

  assign w_hs    = req_q & obi_gnt_i;
  // Same-cycle rvalid is not credited here, keeping ready off the R channel.
  assign cmd_ready_o = (!req_q || obi_gnt_i) &&
                       (({1'b0, cnt_q} + (CW+1)'(w_hs)) < MAX_C);
  assign w_acc   = cmd_valid_i & cmd_ready_o;
  assign w_rv_ok = obi_rvalid_i & (cnt_q != '0);
  assign w_stray = obi_rvalid_i & (cnt_q == '0);
  assign w_push_idx = cnt_q - CW'(w_rv_ok);

  always_comb begin
    w_state = ST_IDLE;
    if (req_q)              w_state = ST_ISSUE;
    else if (cnt_q != '0)   w_state = ST_WAIT;
  end

  assign w_busy = (w_state != ST_IDLE);

  always_comb begin
    req_d       = req_q;
    addr_d      = addr_q;
    we_d        = we_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q + CW'(w_hs) - CW'(w_rv_ok);
    fifo_d      = fifo_q;
    perr_d      = perr_q | w_stray;
    rsp_valid_d = w_rv_ok;
    rsp_we_d    = w_rv_ok & fifo_q[0];
    rsp_rdata_d = (w_rv_ok && !fifo_q[0]) ? obi_rdata_i : '0;

    if (w_acc) begin
      req_d   = 1'b1;
      addr_d  = cmd_addr_i;
      we_d    = cmd_we_i;
      be_d    = cmd_be_i;
      wdata_d = cmd_wdata_i;
    end else if (w_hs) begin
      req_d = 1'b0;
    end

    // Type FIFO occupancy equals cnt_q; pop shifts down, push lands after the survivors.
    if (w_rv_ok) begin
      for (int i = 0; i < MAX_OUTSTANDING - 1; i++) fifo_d[i] = fifo_q[i+1];
      fifo_d[MAX_OUTSTANDING-1] = 1'b0;
    end
    if (w_hs) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        if (CW'(i) == w_push_idx) fifo_d[i] = we_q;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      req_q       <= 1'b0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      be_q        <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      fifo_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_we_q    <= 1'b0;
      rsp_rdata_q <= '0;
      perr_q      <= 1'b0;
    end else begin
      req_q       <= req_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      fifo_q      <= fifo_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_we_q    <= rsp_we_d;
      rsp_rdata_q <= rsp_rdata_d;
      perr_q      <= perr_d;
    end
  end

  assign obi_req_o   = req_q;
  assign obi_addr_o  = addr_q;
  assign obi_we_o    = we_q;
  assign obi_be_o    = be_q;
  assign obi_wdata_o = wdata_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_we_o    = rsp_we_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign busy_o      = w_busy;
  assign proto_err_o = perr_q;

`ifdef OBI_MGR_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_C = TW'(TIMEOUT_CYCLES);

  logic [TW-1:0] wd_q, wd_d;
  logic          tmo_q, tmo_d;

  // Any bus progress restarts the watchdog; the stalled transaction is never aborted.
  always_comb begin
    wd_d  = wd_q;
    tmo_d = tmo_q;
    if (!w_busy || w_hs || obi_rvalid_i) wd_d = '0;
    else if (wd_q != TMO_C)              wd_d = wd_q + TW'(1);
    if (wd_d == TMO_C) tmo_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wd_q  <= '0;
      tmo_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      tmo_q <= tmo_d;
    end
  end

  assign timeout_o = tmo_q;
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout_o      = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_obi_mgr.sv
// Directed bench for obi_mgr with a response scoreboard.
`default_nettype none

module tb_obi_mgr;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic [31:0] cmd_addr_i = '0;
  logic        cmd_we_i = 1'b0;
  logic [3:0]  cmd_be_i = '0;
  logic [31:0] cmd_wdata_i = '0;
  logic        obi_req_o;
  logic        obi_gnt_i = 1'b0;
  logic [31:0] obi_addr_o;
  logic        obi_we_o;
  logic [3:0]  obi_be_o;
  logic [31:0] obi_wdata_o;
  logic        obi_rvalid_i = 1'b0;
  logic [31:0] obi_rdata_i = '0;
  logic        rsp_valid_o;
  logic        rsp_we_o;
  logic [31:0] rsp_rdata_o;
  logic        busy_o;
  logic        proto_err_o;
  logic        timeout_o;

  obi_mgr #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(2), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_addr_i(cmd_addr_i), .cmd_we_i(cmd_we_i), .cmd_be_i(cmd_be_i),
    .cmd_wdata_i(cmd_wdata_i),
    .obi_req_o(obi_req_o), .obi_gnt_i(obi_gnt_i), .obi_addr_o(obi_addr_o),
    .obi_we_o(obi_we_o), .obi_be_o(obi_be_o), .obi_wdata_o(obi_wdata_o),
    .obi_rvalid_i(obi_rvalid_i), .obi_rdata_i(obi_rdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_we_o(rsp_we_o), .rsp_rdata_o(rsp_rdata_o),
    .busy_o(busy_o), .proto_err_o(proto_err_o), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic        we;
    logic [31:0] rdata;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_rsp = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_cmd(input logic [31:0] a, input logic we, input logic [3:0] be,
                          input logic [31:0] wd);
    bit done = 1'b0;
    cmd_addr_i  = a;
    cmd_we_i    = we;
    cmd_be_i    = be;
    cmd_wdata_i = wd;
    cmd_valid_i = 1'b1;
    for (int k = 0; k < 50 && !done; k++) begin
      #1;
      if (cmd_ready_o) done = 1'b1;
      step();
    end
    cmd_valid_i = 1'b0;
    chk("cmd_accept", {63'd0, done}, 64'd1);
  endtask

  always @(negedge clk_i) begin
    if (rstn_i && rsp_valid_o) begin
      exp_t e;
      n_rsp++;
      if (q.size() == 0) begin
        chk("rsp_unexpected", {63'd0, rsp_valid_o}, 64'd0);
      end else begin
        e = q.pop_front();
        chk("rsp_we", {63'd0, rsp_we_o}, {63'd0, e.we});
        chk("rsp_rdata", {32'd0, rsp_rdata_o}, {32'd0, e.rdata});
      end
    end
  end

  initial begin
    // Reset state
    #12;
    chk("rst_req", obi_req_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_ready", cmd_ready_o, 1);
    rstn_i = 1'b1;
    @(negedge clk_i);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_proto", proto_err_o, 0);
    chk("rst_timeout", timeout_o, 0);
    chk("rst_ready2", cmd_ready_o, 1);
    step();

    // Single write, granted immediately
    obi_gnt_i = 1'b1;
    q.push_back('{we: 1'b1, rdata: 32'h0});
    send_cmd(32'h10, 1'b1, 4'hF, 32'hDEADBEEF);
    @(negedge clk_i);
    chk("wr_req", obi_req_o, 1);
    chk("wr_addr", obi_addr_o, 32'h10);
    chk("wr_we", obi_we_o, 1);
    chk("wr_be", obi_be_o, 4'hF);
    chk("wr_wdata", obi_wdata_o, 32'hDEADBEEF);
    step();
    obi_rvalid_i = 1'b1;
    obi_rdata_i  = 32'hCAFE0000;
    step();
    obi_rvalid_i = 1'b0;
    step();
    chk("wr_idle", busy_o, 0);

    // Read with grant stalled three cycles
    obi_gnt_i = 1'b0;
    q.push_back('{we: 1'b0, rdata: 32'h12345678});
    send_cmd(32'h4, 1'b0, 4'hF, 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      chk("stall_req", obi_req_o, 1);
      chk("stall_addr", obi_addr_o, 32'h4);
      chk("stall_we", obi_we_o, 0);
      chk("stall_ready", cmd_ready_o, 0);
      step();
    end
    obi_gnt_i = 1'b1;
    @(negedge clk_i);
    chk("stall_req4", obi_req_o, 1);
    chk("stall_addr4", obi_addr_o, 32'h4);
    step();
    obi_rvalid_i = 1'b1;
    obi_rdata_i  = 32'h12345678;
    step();
    obi_rvalid_i = 1'b0;
    step();
    chk("rd_idle", busy_o, 0);

    // Back-to-back write/read/write, rvalid delayed
    q.push_back('{we: 1'b1, rdata: 32'h0});
    send_cmd(32'h20, 1'b1, 4'hF, 32'h11111111);
    q.push_back('{we: 1'b0, rdata: 32'hA5A50001});
    send_cmd(32'h24, 1'b0, 4'hF, 32'h0);
    q.push_back('{we: 1'b1, rdata: 32'h0});
    cmd_addr_i = 32'h28; cmd_we_i = 1'b1; cmd_be_i = 4'h3; cmd_wdata_i = 32'h33333333;
    cmd_valid_i = 1'b1;
    @(negedge clk_i);
    chk("b2b_blocked0", cmd_ready_o, 0);
    chk("b2b_busy", busy_o, 1);
    step();
    @(negedge clk_i);
    chk("b2b_blocked1", cmd_ready_o, 0);
    chk("b2b_req_drop", obi_req_o, 0);
    step();
    obi_rvalid_i = 1'b1;
    obi_rdata_i  = 32'hFFFFFFFF;
    @(negedge clk_i);
    chk("b2b_no_credit", cmd_ready_o, 0);
    step();
    obi_rvalid_i = 1'b0;
    @(negedge clk_i);
    chk("b2b_unblocked", cmd_ready_o, 1);
    step();
    cmd_valid_i  = 1'b0;
    obi_rvalid_i = 1'b1;
    obi_rdata_i  = 32'hA5A50001;
    @(negedge clk_i);
    chk("b2b_c_addr", obi_addr_o, 32'h28);
    chk("b2b_c_be", obi_be_o, 4'h3);
    step();
    obi_rvalid_i = 1'b1;
    obi_rdata_i  = 32'h5555AAAA;
    step();
    obi_rvalid_i = 1'b0;
    step();
    step();
    chk("b2b_idle", busy_o, 0);

    // Stray rvalid at idle
    chk("stray_pre", proto_err_o, 0);
    obi_rvalid_i = 1'b1;
    obi_rdata_i  = 32'h77777777;
    step();
    obi_rvalid_i = 1'b0;
    @(negedge clk_i);
    chk("stray_proto", proto_err_o, 1);
    chk("stray_no_rsp", rsp_valid_o, 0);
    chk("stray_busy", busy_o, 0);
    step();

    // Asynchronous reset mid-stall
    obi_gnt_i = 1'b0;
    send_cmd(32'h30, 1'b0, 4'hF, 32'h0);
    @(negedge clk_i);
    chk("arst_req_pre", obi_req_o, 1);
    #2 rstn_i = 1'b0;
    #1;
    chk("arst_req", obi_req_o, 0);
    chk("arst_busy", busy_o, 0);
    chk("arst_proto", proto_err_o, 0);
    @(negedge clk_i);
    #2 rstn_i = 1'b1;
    @(negedge clk_i);
    chk("arst_ready", cmd_ready_o, 1);
    step();
    obi_rvalid_i = 1'b1;
    step();
    obi_rvalid_i = 1'b0;
    @(negedge clk_i);
    chk("arst_stray_proto", proto_err_o, 1);
    chk("arst_stray_rsp", rsp_valid_o, 0);
    step();

    // Watchdog on a read that is never granted
    send_cmd(32'h40, 1'b0, 4'hF, 32'h0);
    repeat (7) @(posedge clk_i);
    @(negedge clk_i);
    chk("tmo_before", timeout_o, 0);
    @(posedge clk_i);
    @(negedge clk_i);
`ifdef OBI_MGR_TIMEOUT_EN
    chk("tmo_set", timeout_o, 1);
`else
    chk("tmo_tied", timeout_o, 0);
`endif
    chk("tmo_req_held", obi_req_o, 1);
    chk("tmo_addr_held", obi_addr_o, 32'h40);
    repeat (4) @(posedge clk_i);
    @(negedge clk_i);
`ifdef OBI_MGR_TIMEOUT_EN
    chk("tmo_sticky", timeout_o, 1);
`else
    chk("tmo_tied2", timeout_o, 0);
`endif

    chk("sb_empty", q.size(), 0);
    chk("rsp_count", n_rsp, 5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
